// File: rtl/ras_ctrl_if.sv
// rtl/ras_ctrl_if.sv - request/response bundle between the IF/ID pipeline and the return-address stack controller
//
// Purpose: groups the push/pop/checkpoint requests and the registered prediction
// outputs of ras_ctrl so that they travel as one port.
// Ports (signals):
//   push_valid, push_addr    - link instruction in ID; return address to push
//   pop_valid                - jr $ra decoded in IF; request a prediction
//   ckpt_save, ckpt_restore  - snapshot / roll back stack state
//   ready                    - controller accepts requests this cycle
//   pred_valid, pred_pc      - one-cycle prediction pulse and predicted return PC
//   count                    - live entries, 0..DEPTH
//   overflow, underflow      - one-cycle error pulses
// Modports: master (pipeline side), slave (controller side).
interface ras_ctrl_if #(
  parameter int DEPTH = 32,
  parameter int AW    = 32
);
  localparam int PW = $clog2(DEPTH);

  logic          push_valid;
  logic [AW-1:0] push_addr;
  logic          pop_valid;
  logic          ckpt_save;
  logic          ckpt_restore;
  logic          ready;
  logic          pred_valid;
  logic [AW-1:0] pred_pc;
  logic [PW:0]   count;
  logic          overflow;
  logic          underflow;

  modport master (
    output push_valid, push_addr, pop_valid, ckpt_save, ckpt_restore,
    input  ready, pred_valid, pred_pc, count, overflow, underflow
  );

  modport slave (
    input  push_valid, push_addr, pop_valid, ckpt_save, ckpt_restore,
    output ready, pred_valid, pred_pc, count, overflow, underflow
  );
endinterface

// File: rtl/ras_ctrl.sv
// rtl/ras_ctrl.sv - return-address stack controller with checkpoint/repair for the IF-stage predictor
//
// Purpose: circular return-address stack. Pushes come from link instructions in
// ID, pops from jr $ra in IF. A single checkpoint of {tos, count, top value}
// lets a mispredict flush restore both the pointer and the top entry.
// Ports:
//   CLK    - clock, rising edge
//   RESET  - asynchronous, active-low reset
//   io     - ras_ctrl_if slave modport (requests in, prediction/status out)
module ras_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = 32
) (
  input  logic     CLK,
  input  logic     RESET,
  ras_ctrl_if.slave io
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_MAX  = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_RUN     = 2'd1,
    S_RESTORE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [AW-1:0] mem [DEPTH];

  logic [PW-1:0] tos;
  logic [PW-1:0] top;
  logic [PW-1:0] idx;
  logic [PW:0]   cnt;
  logic [PW-1:0] ckpt_tos;
  logic [PW:0]   ckpt_cnt;
  logic [AW-1:0] ckpt_top;
  logic          pred_valid;
  logic [AW-1:0] pred_pc;
  logic          overflow;
  logic          underflow;

  logic          ready;
  logic          mem_we;
  logic [PW-1:0] mem_waddr;
  logic [AW-1:0] mem_wdata;

  logic          do_push;
  logic          do_pop;

  assign top     = tos - PTR_ONE;
  assign do_push = io.push_valid && !io.pop_valid;
  assign do_pop  = io.pop_valid && !io.push_valid;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= S_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Single memory write port shared by the clear sweep, the repair write and pushes.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = tos;
    mem_wdata  = io.push_addr;
    unique case (state)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = idx;
        mem_wdata = '0;
        if (idx == PTR_LAST) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        ready = 1'b1;
        if (io.ckpt_restore) begin
          state_next = S_RESTORE;
        end else if (do_push) begin
          mem_we = 1'b1;
        end
      end
      S_RESTORE: begin
        // A push after the save may have clobbered the checkpointed top slot.
        mem_we     = 1'b1;
        mem_waddr  = ckpt_tos - PTR_ONE;
        mem_wdata  = ckpt_top;
        state_next = S_RUN;
      end
      default: begin
        state_next = S_INIT;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      idx        <= '0;
      tos        <= '0;
      cnt        <= '0;
      ckpt_tos   <= '0;
      ckpt_cnt   <= '0;
      ckpt_top   <= '0;
      pred_valid <= 1'b0;
      pred_pc    <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      pred_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      idx        <= (state == S_INIT) ? idx + PTR_ONE : '0;
      if (state == S_RUN) begin
        if (io.ckpt_restore) begin
          tos <= ckpt_tos;
          cnt <= ckpt_cnt;
        end else begin
          // Snapshot uses pre-update values; the top value is read even when empty.
          if (io.ckpt_save) begin
            ckpt_tos <= tos;
            ckpt_cnt <= cnt;
            ckpt_top <= mem[top];
          end
          if (io.push_valid && io.pop_valid) begin
            // Call and return in flight together: forward the address, stack untouched.
            pred_valid <= 1'b1;
            pred_pc    <= io.push_addr;
          end else if (do_push) begin
            tos <= tos + PTR_ONE;
            if (cnt == CNT_MAX) begin
              overflow <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end else if (do_pop) begin
            if (cnt != '0) begin
              pred_valid <= 1'b1;
              pred_pc    <= mem[top];
              tos        <= top;
              cnt        <= cnt - CNT_ONE;
            end else begin
              underflow <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign io.ready      = ready;
  assign io.pred_valid = pred_valid;
  assign io.pred_pc    = pred_pc;
  assign io.count      = cnt;
  assign io.overflow   = overflow;
  assign io.underflow  = underflow;
endmodule
